// File: rtl/wb_uart_lite.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_lite
// Brief    : Wishbone slave 8N1 UART with small TX/RX FIFOs, sticky error
//            flags and a registered level interrupt.
// Revision : 1.0 - initial release
// ============================================================================

module wb_uart_lite_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       empty,
    output logic       full,
    output logic       drop
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push, do_pop;

    // Pointer arithmetic; a pop in the same cycle frees the slot for a push.
    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        drop    = push && !do_push;
        wr_d    = wr_q + {{AW{1'b0}}, do_push};
        rd_d    = rd_q + {{AW{1'b0}}, do_pop};
        head    = mem_q[rd_q[AW-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

module wb_uart_lite #(
    parameter int CLKS_PER_BIT = 174,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        uart_rxd_i,
    output logic        uart_txd_o,
    output logic        uart_int_o
);
    localparam int            CW          = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Bus and register state
    logic        ack_q, ack_d, irq_q, irq_d;
    logic [31:0] dat_q, dat_d, rdata;
    logic [1:0]  ctrl_q, ctrl_d, adr;
    logic        tx_ovf_q, tx_ovf_d, ferr_q, ferr_d, rx_ovr_q, rx_ovr_d;
    logic        req, wr_en, rd_en, stat_rd, tx_empty;
    // FIFO hookup
    logic        txf_push, txf_pop, txf_empty, txf_full, txf_drop;
    logic        rxf_push, rxf_pop, rxf_empty, rxf_full, rxf_drop;
    logic [7:0]  txf_head, rxf_head;
    // Transmitter
    state_t      tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d, tx_bit_end;
    // Receiver
    state_t      rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_wait_q, rx_wait_d, rx_s1_q, rx_s2_q, rx_prev_q;
    logic        rx_bit_end, ferr_set;
    logic        unused_bits;

    assign unused_bits = &{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1], rxf_full};

    wb_uart_lite_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .push(txf_push), .pop(txf_pop), .din(wb_dat_i[7:0]),
        .head(txf_head), .empty(txf_empty), .full(txf_full), .drop(txf_drop));

    wb_uart_lite_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .push(rxf_push), .pop(rxf_pop), .din(rx_shift_q),
        .head(rxf_head), .empty(rxf_empty), .full(rxf_full), .drop(rxf_drop));

    // Bus decode, read mux, sticky flags, control register and interrupt.
    always_comb begin
        adr      = wb_adr_i[3:2];
        req      = wb_cyc_i && wb_stb_i && !ack_q;
        wr_en    = req && wb_we_i && wb_sel_i[0];
        rd_en    = req && !wb_we_i;
        stat_rd  = rd_en && (adr == 2'd2);
        txf_push = wr_en && (adr == 2'd0);
        rxf_pop  = rd_en && (adr == 2'd1);
        tx_empty = txf_empty && (tx_state_q == S_IDLE);
        rdata    = '0;
        case (adr)
            2'd1:    rdata = rxf_empty ? 32'd0 : {24'd0, rxf_head};
            2'd2:    rdata = {26'd0, tx_ovf_q, ferr_q, rx_ovr_q, tx_empty, txf_full, !rxf_empty};
            2'd3:    rdata = {30'd0, ctrl_q};
            default: rdata = '0;
        endcase
        ack_d    = req;
        dat_d    = rd_en ? rdata : 32'd0;
        ctrl_d   = (wr_en && (adr == 2'd3)) ? wb_dat_i[1:0] : ctrl_q;
        // A set event in the clearing cycle wins.
        tx_ovf_d = txf_drop || (tx_ovf_q && !stat_rd);
        ferr_d   = ferr_set || (ferr_q && !stat_rd);
        rx_ovr_d = rxf_drop || (rx_ovr_q && !stat_rd);
        irq_d    = (ctrl_q[0] && !rxf_empty) || (ctrl_q[1] && tx_empty);
    end

    // Transmit FSM: pops a byte on entering START, back-to-back frames allowed.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txf_pop    = 1'b0;
        tx_bit_end = (tx_cnt_q == C_BIT_LAST);
        if (tx_state_q != S_IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
        case (tx_state_q)
            S_IDLE: if (!txf_empty) begin
                txf_pop    = 1'b1;
                tx_shift_d = txf_head;
                tx_cnt_d   = '0;
                tx_state_d = S_START;
            end
            S_START: if (tx_bit_end) begin
                tx_bit_d   = 3'd0;
                tx_state_d = S_DATA;
            end
            S_DATA: if (tx_bit_end) begin
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
            end
            S_STOP: if (tx_bit_end) begin
                if (!txf_empty) begin
                    txf_pop    = 1'b1;
                    tx_shift_d = txf_head;
                    tx_state_d = S_START;
                end else begin
                    tx_state_d = S_IDLE;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        // Line level follows the registered state, giving a glitch-free pin.
        txd_d = (tx_state_q == S_START) ? 1'b0 :
                (tx_state_q == S_DATA)  ? tx_shift_q[0] : 1'b1;
    end

    // Receive FSM: mid-bit sampling, glitch rejection and framing-error recovery.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_wait_d  = rx_wait_q;
        rxf_push   = 1'b0;
        ferr_set   = 1'b0;
        rx_bit_end = (rx_cnt_q == C_BIT_LAST);
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == C_HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = 3'd0;
                rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end else begin
                rx_cnt_d = rx_cnt_q + CW'(1);
            end
            S_DATA: if (rx_bit_end) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            end else begin
                rx_cnt_d = rx_cnt_q + CW'(1);
            end
            S_STOP: if (rx_wait_q) begin
                // Hold off after a framing error until the line is released.
                if (rx_s2_q) begin
                    rx_wait_d  = 1'b0;
                    rx_state_d = S_IDLE;
                end
            end else if (rx_bit_end) begin
                rx_cnt_d = '0;
                if (rx_s2_q) begin
                    rxf_push   = 1'b1;
                    rx_state_d = S_IDLE;
                end else begin
                    ferr_set  = 1'b1;
                    rx_wait_d = 1'b1;
                end
            end else begin
                rx_cnt_d = rx_cnt_q + CW'(1);
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any frame in flight and idles the line.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            ctrl_q     <= '0;
            irq_q      <= 1'b0;
            tx_ovf_q   <= 1'b0;
            ferr_q     <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_wait_q  <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            ctrl_q     <= ctrl_d;
            irq_q      <= irq_d;
            tx_ovf_q   <= tx_ovf_d;
            ferr_q     <= ferr_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_wait_q  <= rx_wait_d;
            rx_s1_q    <= uart_rxd_i;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign uart_txd_o = txd_q;
    assign uart_int_o = irq_q;
endmodule
`default_nettype wire
